// File: rtl/uart_prog_loader.sv
// Assembles little-endian 32-bit words from a UART byte stream and writes them
// to the program ROM. The frame starts with a 16-bit word count.
module uart_prog_loader #(
    parameter int ADDR_W         = 14,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              err_o
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       rem_q, rem_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic [15:0]       n_words;
    logic [TMO_W-1:0]  tmo_inc;
    logic              tmo_hit;

    assign n_words = {rx_data, len_lo_q};
    assign tmo_inc = tmo_q + 1'b1;
    assign tmo_hit = (tmo_inc >= TMO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_lo_q <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            idx_q    <= '0;
            rem_q    <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        tmo_d    = tmo_q;
        if (!load_en) begin
            state_d = S_IDLE;
            adr_d   = '0;
            idx_d   = '0;
            rem_d   = '0;
            tmo_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_LEN_LO;
                    tmo_d   = '0;
                end
                S_LEN_LO: begin
                    if (rx_valid) begin
                        len_lo_d = rx_data;
                        tmo_d    = '0;
                        state_d  = S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (rx_valid) begin
                        tmo_d = '0;
                        if (n_words == 16'd0) begin
                            state_d = S_DONE;
                        end else if (32'(n_words) > (32'd1 << ADDR_W)) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                            adr_d   = '0;
                            idx_d   = '0;
                            rem_d   = n_words;
                            dat_d   = '0;
                        end
                    end else if (tmo_hit) begin
                        state_d = S_ERR;
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        tmo_d                    = '0;
                        dat_d[{idx_q, 3'b000} +: 8] = rx_data;
                        idx_d                    = idx_q + 2'd1;
                        if (idx_q == 2'd3) state_d = S_WRITE;
                    end else if (tmo_hit) begin
                        // a partially assembled word is dropped, never written
                        state_d = S_ERR;
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
                S_WRITE: begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DATA;
                        adr_d   = adr_q + 1'b1;
                        // byte arriving during the strobe starts the next word
                        if (rx_valid) begin
                            dat_d[7:0] = rx_data;
                            idx_d      = 2'd1;
                            tmo_d      = '0;
                        end
                    end
                end
                S_DONE, S_ERR: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign upg_wen_o  = (state_q == S_WRITE);
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = (state_q == S_DONE);
    assign err_o      = (state_q == S_ERR);
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: write scoreboard checked at every strobe,
// plus direct checks of done/err/reset behaviour.
module tb_uart_prog_loader;
    localparam int ADDR_W = 14;
    localparam int TMO    = 100;

    logic              clk, rst_n, load_en, rx_valid;
    logic [7:0]        rx_data;
    logic              upg_wen_o, upg_done_o, err_o;
    logic [ADDR_W-1:0] upg_adr_o;
    logic [31:0]       upg_dat_o;

    typedef struct {
        logic [ADDR_W-1:0] adr;
        logic [31:0]       dat;
    } wr_t;

    wr_t exp_q[$];
    int  vectors    = 0;
    int  miscompares = 0;
    int  wen_cnt    = 0;
    int  wen_base;

    uart_prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .rx_valid(rx_valid), .rx_data(rx_data),
        .upg_wen_o(upg_wen_o), .upg_adr_o(upg_adr_o), .upg_dat_o(upg_dat_o),
        .upg_done_o(upg_done_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        wr_t w;
        w.adr = a;
        w.dat = d;
        exp_q.push_back(w);
    endtask

    // leave whatever state, then enter LEN_LO
    task automatic restart();
        load_en = 1'b0;
        tick(1);
        load_en = 1'b1;
        tick(1);
    endtask

    // scoreboard: every strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && upg_wen_o === 1'b1) begin
            wen_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_wen", 32'd1, 32'd0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_adr", 32'(upg_adr_o), 32'(w.adr));
                check("wr_dat", upg_dat_o, w.dat);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        load_en  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick(2);
        check("rst_wen",  32'(upg_wen_o),  32'd0);
        check("rst_adr",  32'(upg_adr_o),  32'd0);
        check("rst_dat",  upg_dat_o,       32'd0);
        check("rst_done", 32'(upg_done_o), 32'd0);
        check("rst_err",  32'(err_o),      32'd0);
        rst_n = 1'b1;
        tick(1);

        // 1: two-word image
        load_en = 1'b1;
        tick(1);
        wen_base = wen_cnt;
        push(0, 32'h0000_0013);
        push(1, 32'h0010_0093);
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        check("t1_done_during_wr", 32'(upg_done_o), 32'd0);
        tick(1);
        check("t1_done", 32'(upg_done_o), 32'd1);
        check("t1_wen_pulses", 32'(wen_cnt - wen_base), 32'd2);
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // 2: zero-length image, then length overflow
        restart();
        check("t2_done_cleared", 32'(upg_done_o), 32'd0);
        wen_base = wen_cnt;
        send(8'h00); send(8'h00);
        check("t2_zero_done", 32'(upg_done_o), 32'd1);
        restart();
        send(8'h01); send(8'h40);
        check("t2_ovf_err", 32'(err_o), 32'd1);
        check("t2_ovf_done", 32'(upg_done_o), 32'd0);
        check("t2_no_wen", 32'(wen_cnt - wen_base), 32'd0);

        // 3: inter-byte timeout with a partial word
        restart();
        check("t3_err_cleared", 32'(err_o), 32'd0);
        send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
        tick(TMO / 2);
        check("t3_no_early_err", 32'(err_o), 32'd0);
        tick(TMO / 2 + 10);
        check("t3_tmo_err", 32'(err_o), 32'd1);
        check("t3_no_wen", 32'(wen_cnt - wen_base), 32'd0);

        // 4: abort after 5 data bytes, then fresh N=1 frame lands at adr0
        restart();
        push(0, 32'h4433_2211);
        send(8'h02); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        load_en = 1'b0;
        tick(1);
        check("t4_abort_done", 32'(upg_done_o), 32'd0);
        check("t4_abort_err", 32'(err_o), 32'd0);
        load_en = 1'b1;
        tick(1);
        push(0, 32'hEFBE_ADDE);
        send(8'h01); send(8'h00);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        tick(1);
        check("t4_done", 32'(upg_done_o), 32'd1);
        check("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // 5: back-to-back bytes, N=3, bytes arrive during each strobe
        restart();
        wen_base = wen_cnt;
        push(0, 32'h0302_0100);
        push(1, 32'h0706_0504);
        push(2, 32'h0B0A_0908);
        send(8'h03); send(8'h00);
        for (int i = 0; i < 12; i++) send(8'(i));
        tick(1);
        check("t5_done", 32'(upg_done_o), 32'd1);
        check("t5_wen_pulses", 32'(wen_cnt - wen_base), 32'd3);
        check("t5_q_empty", 32'(exp_q.size()), 32'd0);

        // 6: bytes after done are ignored; done clears with load_en
        wen_base = wen_cnt;
        send(8'hFF); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        tick(2);
        check("t6_no_wen", 32'(wen_cnt - wen_base), 32'd0);
        check("t6_done_sticky", 32'(upg_done_o), 32'd1);
        check("t6_adr_hold", 32'(upg_adr_o), 32'd2);
        load_en = 1'b0;
        tick(1);
        check("t6_done_drop", 32'(upg_done_o), 32'd0);

        // 5b: asynchronous reset in the middle of DATA
        load_en = 1'b1;
        tick(1);
        send(8'h01); send(8'h00); send(8'hAA);
        check("t5b_partial_dat", upg_dat_o, 32'h0000_00AA);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5b_async_dat", upg_dat_o, 32'd0);
        check("t5b_async_adr", 32'(upg_adr_o), 32'd0);
        check("t5b_async_wen", 32'(upg_wen_o), 32'd0);
        check("t5b_async_done", 32'(upg_done_o), 32'd0);
        check("t5b_async_err", 32'(err_o), 32'd0);
        tick(1);
        rst_n = 1'b1;
        // a restart must begin with a fresh length
        tick(1);
        push(0, 32'h0403_0201);
        send(8'h01); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        tick(1);
        check("t5b_restart_done", 32'(upg_done_o), 32'd1);
        check("t5b_q_empty", 32'(exp_q.size()), 32'd0);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
